rv_decode_stage: RTL
====================

# rv_decode_stage

Pipelined, parametrised RISC-V instruction decode stage sitting between fetch and issue. Accepts one 32-bit instruction plus PC per cycle over valid/ready. Extracts register/function fields, generates the XLEN-wide sign-extended immediate and flags illegal encodings for RV32I or RV64I. Outputs come from a registered 2-entry skid buffer with flush and decode statistics counters.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64 (elaboration error otherwise).
- PC_WIDTH, 32, width of the PC passed alongside each instruction.
- STRICT_DECODE, 1, 1 = full funct3/funct7/funct12 legality checks; 0 = opcode and inst[1:0] checks only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties the buffer.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  raw instruction.
- in_pc  in  PC_WIDTH  instruction PC.
- out_valid  out  1  decoded entry at head valid.
- out_ready  in  1  consumer accepts head.
- out_inst  out  32  raw instruction echo.
- out_pc  out  PC_WIDTH  PC echo.
- out_opcode  out  7  inst[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / [19:15] / [24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_funct12  out  12  inst[31:20].
- out_imm  out  XLEN  sign-extended immediate.
- out_decode_error  out  1  illegal encoding.
- stat_decoded  out  32  count of output handshakes, wraps.
- stat_errors  out  16  count of output handshakes with error, saturating.

## Operation
- Decode is combinational on in_inst; results written into buffer on input handshake (in_valid && in_ready).
- Immediate by opcode: STORE 0x23 S-type {inst[31:25],inst[11:7]}; LUI 0x37/AUIPC 0x17 U-type {inst[31:12],12'b0}; JAL 0x6F J-type {inst[31],inst[19:12],inst[20],inst[30:21],0}; BRANCH 0x63 B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}; all others I-type inst[31:20]. Every format sign-extends from inst[31] to XLEN (U-type included on XLEN=64).
- Legal opcodes: 0x33,0x13,0x03,0x23,0x37,0x17,0x6F,0x67,0x63,0x73,0x0F; plus 0x1B,0x3B when XLEN=64. inst[1:0]!=2'b11 or other opcode -> error.
- STRICT_DECODE=1 additionally flags: LOAD funct3 3/6 (legal only XLEN=64), 7; STORE funct3>2 (3 legal only XLEN=64); BRANCH funct3 2,3; JALR funct3!=0; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; IMM funct3 1 with nonzero shamt-upper bits (inst[31:25] XLEN32, inst[31:26] XLEN64), funct3 5 upper bits not 0/0x20 (XLEN64: inst[31:26] not 0/0x10); OP-32/IMM-32 same rules with 5-bit shamt; SYSTEM funct3 4; SYSTEM funct3 0 with funct12 not in {0x000,0x001,0x302,0x105} or rd/rs1 nonzero.
- Errored instructions still pass through in order; all fields still populated.
- Buffer: 2 entries, FIFO order. in_ready = occupancy<2 after the current edge. Simultaneous in/out handshake at occupancy 1 or 2 keeps occupancy.
- Flush: occupancy->0, out_valid->0 next cycle; in_valid in flush cycle is dropped; counters untouched; flush wins over any handshake that cycle.
- stat_decoded +1 per output handshake (wraps 0xFFFFFFFF->0); stat_errors +1 when head has error, holds at 0xFFFF.

## Timing
- Reset (rst_n low, asynchronous): occupancy 0, out_valid 0, in_ready 0, all out_* data 0, counters 0. in_ready becomes 1 on first rising edge after rst_n rises.
- Latency: input handshake at edge N -> out_valid high after edge N, visible cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high.
- out_* data stable while out_valid && !out_ready.
- No combinational path from out_ready or in_valid to in_ready.

## Test plan
- Reset then ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid, rd=1, imm=0xFFFFFFFF, error=0, stat_decoded=1.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm 0xFFFFFFFC; XLEN=64 LUI x5,0x80000 (0x800002B7) -> imm 0xFFFFFFFF80000000.
- 0x00000000 and SUB-form funct7 0x20 with funct3 1 (0x40001033) -> error=1, stat_errors=2; STRICT_DECODE=0 -> second is error=0.
- out_ready=0, push three instructions: first two accepted, in_ready=0 after second, third held; raise out_ready -> outputs emerge in order, one per cycle.
- Buffer full, assert flush with in_valid=1 -> out_valid=0, in_ready=1 next cycle, dropped instruction never appears, counters unchanged.
- Preload stat_errors to 0xFFFF via 65535 errored instrs (or force) then one more -> holds 0xFFFF; rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: combinational field/immediate/legality decode feeding a
// registered 2-entry FIFO output buffer with flush and handshake statistics.
module rv_decode_stage #(
  parameter int XLEN          = 32,
  parameter int PC_WIDTH      = 32,
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [11:0]         out_funct12,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_decode_error,
  output logic [31:0]         stat_decoded,
  output logic [15:0]         stat_errors
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("rv_decode_stage: XLEN must be 32 or 64");
  end

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_OP_IMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;
  localparam logic [6:0] OPC_FENCE   = 7'h0F;
  localparam logic [6:0] OPC_IMM_32  = 7'h1B;
  localparam logic [6:0] OPC_OP_32   = 7'h3B;

  typedef struct packed {
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     imm;
    logic                err;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm_ext;
  logic        op_known;
  logic        strict_bad;
  logic        decode_error;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign funct7  = in_inst[31:25];
  assign funct12 = in_inst[31:20];

  always_comb begin
    imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    case (opcode)
      OPC_STORE:          imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      OPC_LUI, OPC_AUIPC: imm32 = {in_inst[31:12], 12'b0};
      OPC_JAL:            imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      OPC_BRANCH:         imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      default:            ;
    endcase
    // Every format is a signed 32-bit value first, then widened to XLEN.
    imm_ext = {XLEN{imm32[31]}};
    imm_ext[31:0] = imm32;
  end

  always_comb begin
    op_known   = 1'b0;
    strict_bad = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        op_known   = (opcode == OPC_OP) || RV64;
        strict_bad = !(funct7 == 7'h00 ||
                       (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OPC_OP_IMM: begin
        op_known = 1'b1;
        if (funct3 == 3'd1)
          strict_bad = RV64 ? (in_inst[31:26] != 6'h00) : (funct7 != 7'h00);
        else if (funct3 == 3'd5)
          strict_bad = RV64 ? !(in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10)
                            : !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OPC_IMM_32: begin
        op_known = RV64;
        if (funct3 == 3'd1)
          strict_bad = (funct7 != 7'h00);
        else if (funct3 == 3'd5)
          strict_bad = !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OPC_LOAD: begin
        op_known   = 1'b1;
        strict_bad = (funct3 == 3'd7) || (!RV64 && (funct3 == 3'd3 || funct3 == 3'd6));
      end
      OPC_STORE: begin
        op_known   = 1'b1;
        strict_bad = (funct3 > 3'd3) || (funct3 == 3'd3 && !RV64);
      end
      OPC_JALR: begin
        op_known   = 1'b1;
        strict_bad = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        op_known   = 1'b1;
        strict_bad = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_SYSTEM: begin
        op_known   = 1'b1;
        strict_bad = (funct3 == 3'd4) ||
                     (funct3 == 3'd0 &&
                      (!(funct12 inside {12'h000, 12'h001, 12'h302, 12'h105}) ||
                       in_inst[11:7] != 5'd0 || in_inst[19:15] != 5'd0));
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: op_known = 1'b1;
      default: ;
    endcase
    // The opcode table already requires inst[1:0] == 2'b11.
    decode_error = !op_known || (STRICT_DECODE && strict_bad);
  end

  entry_t      head_reg, tail_reg, new_entry;
  logic [1:0]  occ_reg, occ_next;
  logic        in_ready_reg, out_valid_reg;
  logic [31:0] stat_decoded_reg;
  logic [15:0] stat_errors_reg;
  logic        push, pop;

  assign new_entry = '{inst: in_inst, pc: in_pc, imm: imm_ext, err: decode_error};

  // Flush suppresses both handshakes so nothing is enqueued or counted that cycle.
  assign push = in_valid && in_ready_reg && !flush;
  assign pop  = out_valid_reg && out_ready && !flush;

  always_comb begin
    occ_next = occ_reg;
    if (push && !pop)
      occ_next = occ_reg + 2'd1;
    else if (pop && !push)
      occ_next = occ_reg - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      occ_reg          <= 2'd0;
      in_ready_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      stat_decoded_reg <= 32'd0;
      stat_errors_reg  <= 16'd0;
    end else if (flush) begin
      occ_reg       <= 2'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      occ_reg       <= occ_next;
      in_ready_reg  <= (occ_next != 2'd2);
      out_valid_reg <= (occ_next != 2'd0);
      if (pop) begin
        if (occ_reg == 2'd2) begin
          head_reg <= tail_reg;
          if (push)
            tail_reg <= new_entry;
        end else if (push) begin
          head_reg <= new_entry;
        end
      end else if (push) begin
        if (occ_reg == 2'd0)
          head_reg <= new_entry;
        else
          tail_reg <= new_entry;
      end
      if (pop) begin
        stat_decoded_reg <= stat_decoded_reg + 32'd1;
        if (head_reg.err && stat_errors_reg != 16'hFFFF)
          stat_errors_reg <= stat_errors_reg + 16'd1;
      end
    end
  end

  assign in_ready         = in_ready_reg;
  assign out_valid        = out_valid_reg;
  assign out_inst         = head_reg.inst;
  assign out_pc           = head_reg.pc;
  assign out_opcode       = head_reg.inst[6:0];
  assign out_rd           = head_reg.inst[11:7];
  assign out_rs1          = head_reg.inst[19:15];
  assign out_rs2          = head_reg.inst[24:20];
  assign out_funct3       = head_reg.inst[14:12];
  assign out_funct7       = head_reg.inst[31:25];
  assign out_funct12      = head_reg.inst[31:20];
  assign out_imm          = head_reg.imm;
  assign out_decode_error = head_reg.err;
  assign stat_decoded     = stat_decoded_reg;
  assign stat_errors      = stat_errors_reg;

endmodule
